// File: rtl/uart_piso_frame.sv
// UART transmit serializer: start bit, DATA_W data bits, optional parity, STOP_BITS stop bits.
// Optional parity stage is compiled in with the UART_PISO_PARITY_EN macro.
module uart_piso_frame #(
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              baud_tick,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              load_data,
  output logic              ready,
  output logic              data_bit,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

`ifdef UART_PISO_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } state_t;
`endif

  state_t            state_r;
  logic [DATA_W-1:0] shift_r;
  logic [CNT_W-1:0]  cnt_r;
`ifdef UART_PISO_PARITY_EN
  logic              parity_r;

  function automatic logic parity_of(input logic [DATA_W-1:0] w);
    return (^w) ^ (PARITY_ODD != 0);
  endfunction
`endif

  // Next bit to drive on the line, taken from the end selected by bit order.
  function automatic logic out_bit(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] shift_next(input logic [DATA_W-1:0] w);
    return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  assign ready = (state_r == IDLE);

  // Frame sequencer; line, busy and done are all registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      data_bit <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      shift_r  <= '0;
      cnt_r    <= '0;
`ifdef UART_PISO_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          data_bit <= 1'b1;
          busy     <= 1'b0;
          if (load_data) begin
            shift_r  <= tx_data;
`ifdef UART_PISO_PARITY_EN
            parity_r <= parity_of(tx_data);
`endif
            cnt_r    <= '0;
            state_r  <= START;
            data_bit <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (baud_tick) begin
            data_bit <= out_bit(shift_r);
            shift_r  <= shift_next(shift_r);
            cnt_r    <= '0;
            state_r  <= DATA;
          end
        end
        // cnt_r tracks which data bit is currently on the line.
        DATA: begin
          if (baud_tick) begin
            if (cnt_r == LAST_DATA) begin
              cnt_r    <= '0;
`ifdef UART_PISO_PARITY_EN
              state_r  <= PARITY;
              data_bit <= parity_r;
`else
              state_r  <= STOP;
              data_bit <= 1'b1;
`endif
            end else begin
              data_bit <= out_bit(shift_r);
              shift_r  <= shift_next(shift_r);
              cnt_r    <= cnt_r + CNT_W'(1);
            end
          end
        end
`ifdef UART_PISO_PARITY_EN
        PARITY: begin
          if (baud_tick) begin
            cnt_r    <= '0;
            state_r  <= STOP;
            data_bit <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_tick) begin
            if (cnt_r == LAST_STOP) begin
              cnt_r   <= '0;
              state_r <= IDLE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end
        default: begin
          state_r  <= IDLE;
          data_bit <= 1'b1;
          busy     <= 1'b0;
          cnt_r    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_piso_frame.sv
// Directed bench for uart_piso_frame: several parameter variants share clock, reset and baud tick.
// Parity variants are instantiated only when UART_PISO_PARITY_EN is defined.
module tb_uart_piso_frame;

`ifdef UART_PISO_PARITY_EN
  localparam int NINST = 5;
`else
  localparam int NINST = 3;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] tx_v     [NINST];
  logic       load_v   [NINST];
  logic       ready_v  [NINST];
  logic       data_bit_v [NINST];
  logic       busy_v   [NINST];
  logic       done_v   [NINST];

  int checks = 0;
  int failures = 0;
  int ph = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: MSB first, 2: two stop bits, 3/4: even/odd parity
  uart_piso_frame dut_lsb (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_v[0]), .load_data(load_v[0]),
    .ready(ready_v[0]), .data_bit(data_bit_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_piso_frame #(.MSB_FIRST(1)) dut_msb (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_v[1]), .load_data(load_v[1]),
    .ready(ready_v[1]), .data_bit(data_bit_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_piso_frame #(.STOP_BITS(2)) dut_stop2 (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_v[2]), .load_data(load_v[2]),
    .ready(ready_v[2]), .data_bit(data_bit_v[2]), .busy(busy_v[2]), .done(done_v[2]));
`ifdef UART_PISO_PARITY_EN
  uart_piso_frame #(.PARITY_ODD(0)) dut_peven (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_v[3]), .load_data(load_v[3]),
    .ready(ready_v[3]), .data_bit(data_bit_v[3]), .busy(busy_v[3]), .done(done_v[3]));
  uart_piso_frame #(.PARITY_ODD(1)) dut_podd (
    .clk(clk), .reset(reset), .baud_tick(baud_tick), .tx_data(tx_v[4]), .load_data(load_v[4]),
    .ready(ready_v[4]), .data_bit(data_bit_v[4]), .busy(busy_v[4]), .done(done_v[4]));
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock; lands on the falling edge and sets up baud_tick for the next rising edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    ph = (ph + 1) % 4;
    baud_tick = (ph == 3);
  endtask

  task automatic align_tick();
    int guard = 0;
    while (!baud_tick && guard < 8) begin
      cyc();
      guard++;
    end
  endtask

  // exp holds the expected line value for each tick period, start bit first.
  task automatic run_frame(input int sel, input logic [7:0] word, input string exp,
                           input bit hold, input bit glitch, input string tag);
    int n = exp.len();
    int early = 0;
    int guard;
    load_v[sel] = 1'b1;
    tx_v[sel] = word;
    cyc();
    if (!hold) load_v[sel] = 1'b0;
    tx_v[sel] = ~word;
    check({tag, "_busy_acc"}, {31'd0, busy_v[sel]}, 32'd1);
    check({tag, "_ready_acc"}, {31'd0, ready_v[sel]}, 32'd0);
    for (int i = 0; i < n; i++) begin
      guard = 0;
      while (!baud_tick && guard < 16) begin
        cyc();
        if (done_v[sel]) early++;
        guard++;
      end
      check($sformatf("%s_bit%0d", tag, i), {31'd0, data_bit_v[sel]},
            (exp[i] == 8'h31) ? 32'd1 : 32'd0);
      if (i == 0 || i == n - 1)
        check($sformatf("%s_ready%0d", tag, i), {31'd0, ready_v[sel]}, 32'd0);
      if (glitch && i == 4) begin
        load_v[sel] = 1'b1;
        tx_v[sel] = 8'h55;
      end
      cyc();
      if (glitch && i == 4) load_v[sel] = 1'b0;
      if (i < n - 1 && done_v[sel]) early++;
      if (guard >= 16) check({tag, "_tick_timeout"}, 32'd1, 32'd0);
    end
    check({tag, "_done"}, {31'd0, done_v[sel]}, 32'd1);
    check({tag, "_busy_end"}, {31'd0, busy_v[sel]}, 32'd0);
    check({tag, "_ready_end"}, {31'd0, ready_v[sel]}, 32'd1);
    check({tag, "_line_end"}, {31'd0, data_bit_v[sel]}, 32'd1);
    check({tag, "_early_done"}, early, 32'd0);
    if (!hold) begin
      cyc();
      check({tag, "_done_pulse"}, {31'd0, done_v[sel]}, 32'd0);
      check({tag, "_idle_line"}, {31'd0, data_bit_v[sel]}, 32'd1);
    end
  endtask

  initial begin
    for (int k = 0; k < NINST; k++) begin
      tx_v[k] = 8'h00;
      load_v[k] = 1'b0;
    end
    reset = 1'b1;
    cyc(); cyc(); cyc();
    for (int k = 0; k < NINST; k++) begin
      check($sformatf("rst_line%0d", k), {31'd0, data_bit_v[k]}, 32'd1);
      check($sformatf("rst_busy%0d", k), {31'd0, busy_v[k]}, 32'd0);
      check($sformatf("rst_done%0d", k), {31'd0, done_v[k]}, 32'd0);
      check($sformatf("rst_ready%0d", k), {31'd0, ready_v[k]}, 32'd1);
    end
    reset = 1'b0;
    cyc();

    // Acceptance coincides with a tick, which must not end the start bit early.
    align_tick();
    run_frame(0, 8'hA5, "0101001011", 1'b0, 1'b0, "lsb_a5");
    run_frame(0, 8'h01, "0100000001", 1'b0, 1'b0, "lsb_01");
    run_frame(1, 8'hA5, "0101001011", 1'b0, 1'b0, "msb_a5");
    run_frame(1, 8'h01, "0000000011", 1'b0, 1'b0, "msb_01");

    // Back-to-back with load_data held high across both frames.
    run_frame(2, 8'h3C, "00011110011", 1'b1, 1'b0, "stop2_3c");
    run_frame(2, 8'h81, "01000000111", 1'b0, 1'b0, "stop2_81");

`ifdef UART_PISO_PARITY_EN
    run_frame(3, 8'hA5, "01010010101", 1'b0, 1'b0, "peven_a5");
    run_frame(3, 8'h07, "01110000011", 1'b0, 1'b0, "peven_07");
    run_frame(4, 8'h07, "01110000001", 1'b0, 1'b0, "podd_07");
`endif

    // Abort 0xFF while data bit 3 is on the line.
    load_v[0] = 1'b1;
    tx_v[0] = 8'hFF;
    cyc();
    load_v[0] = 1'b0;
    for (int t = 0; t < 4; t++) begin
      align_tick();
      cyc();
    end
    check("abort_midframe_busy", {31'd0, busy_v[0]}, 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("abort_line", {31'd0, data_bit_v[0]}, 32'd1);
    check("abort_busy", {31'd0, busy_v[0]}, 32'd0);
    check("abort_ready", {31'd0, ready_v[0]}, 32'd1);
    run_frame(0, 8'h00, "0000000001", 1'b0, 1'b0, "post_abort_00");

    // A load pulse mid-frame is dropped and starts no second frame.
    run_frame(0, 8'hA5, "0101001011", 1'b0, 1'b1, "ignore_55");
    for (int t = 0; t < 40; t++) cyc();
    check("ignore_no_second_busy", {31'd0, busy_v[0]}, 32'd0);
    check("ignore_no_second_line", {31'd0, data_bit_v[0]}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_piso_frame.md
Name: uart_piso_frame

Overview:
- Parametrised UART transmit serializer; next generation of the 8-bit PISO.
- Accepts a parallel word through a valid/ready handshake and frames it as start, data, optional parity, then stop bit(s).
- Advances one bit per baud_tick strobe and sits between the TX holding logic and the TX pin driver.
- Adds what the plain shifter lacks: framing, bit ordering, busy/done status and back-pressure.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..16.
STOP_BITS, 1, stop bits per frame; 1 or 2.
MSB_FIRST, 0, 0 = LSB transmitted first, 1 = MSB first.
PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd. Ignored otherwise.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
baud_tick  input  1  one-clk bit-period strobe from the baud generator.
tx_data  input  DATA_W  parallel word to send.
load_data  input  1  valid; word accepted when load_data && ready.
ready  output  1  high only in IDLE; combinational from state.
data_bit  output  1  serial line, registered; idle level is 1.
busy  output  1  high in every state except IDLE; registered.
done  output  1  one-clk pulse at end of last stop bit.

Behaviour:
- Reset (sync, active-high): state=IDLE, data_bit=1, busy=0, done=0, shift register=0, bit counter=0. Reset mid-frame aborts the frame; line is 1 on the cycle after reset is sampled.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - data_bit=1, ready=1. baud_tick is ignored.
  - On load_data: capture tx_data into the shift register and compute parity over tx_data.
  - Next cycle: state=START, data_bit=0, busy=1.
- Each non-IDLE state holds its bit until a cycle with baud_tick=1. On that edge the block moves to the next bit or state and updates data_bit.
- A tick in the same cycle as acceptance does not count. The start bit spans from the cycle after acceptance through the first subsequent tick.
- DATA:
  - Emits DATA_W bits, LSB first (shift right) or MSB first (shift left) per MSB_FIRST.
  - Bit counter is $clog2(DATA_W)+1 bits wide and counts 0..DATA_W-1. The tick at count DATA_W-1 exits the state.
- PARITY (macro only): one bit. Value = XOR of data bits, XOR PARITY_ODD.
- STOP:
  - data_bit=1 for STOP_BITS tick periods.
  - On the final tick: state=IDLE, done=1 for that one cycle, busy=0.
  - ready rises the next cycle. Back-to-back accept is possible that cycle, giving zero idle gap beyond the stop bit(s).
- load_data while busy: ignored, no capture. tx_data may change freely after acceptance.
- Frame length in ticks:
  - Without parity: 1 + DATA_W + STOP_BITS.
  - With parity: one more tick.

Optional Feature:
- Macro: UART_PISO_PARITY_EN.
- Defined: PARITY state is present and the parity bit is inserted between the last data bit and the first stop bit, with sense set by PARITY_ODD.
- Undefined: no PARITY state, DATA goes directly to STOP, and PARITY_ODD has no effect.

Test Plan:
1. Defaults, no macro, baud_tick every 4 clks, tx_data=0xA5 pulsed once -> data_bit sequence per tick 0,1,0,1,0,0,1,0,1,1. done pulses once after 10 ticks. Line then 1.
2. MSB_FIRST=1, tx_data=0xA5 -> 0,1,0,1,0,0,1,0,1,1 mirrored data field, i.e. 0 then 1,0,1,0,0,1,0,1 then 1.
3. UART_PISO_PARITY_EN, PARITY_ODD=0, 0xA5 -> parity bit 0, 11-tick frame. Same with 0x07 -> parity 1. PARITY_ODD=1 with 0x07 -> parity 0.
4. STOP_BITS=2, load_data held high with 0x3C then 0x81 -> ready=0 during frame, second word accepted the cycle ready rises. Two stop ticks of 1 precede the next start bit.
5. Reset asserted at data bit 3 of 0xFF -> data_bit=1, busy=0, ready=1 next cycle. A new load of 0x00 frames correctly.
6. load_data pulsed mid-frame with 0x55 -> ignored; in-flight word completes unchanged and no second frame follows.
